// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: one slave port shared by N_MASTERS masters, grant held
// for the whole CYC, priority rotated on release, watchdog aborts stalled cycles with ERR.
module wb_rr_arbiter #(
   parameter int N_MASTERS      = 3,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_MASTERS-1:0]    m_cyc_i,
   input  logic [N_MASTERS-1:0]    m_stb_i,
   input  logic [N_MASTERS-1:0]    m_we_i,
   input  logic [32*N_MASTERS-1:0] m_adr_i,
   input  logic [32*N_MASTERS-1:0] m_dat_i,
   input  logic [4*N_MASTERS-1:0]  m_sel_i,
   output logic [31:0]             m_dat_o,
   output logic [N_MASTERS-1:0]    m_ack_o,
   output logic [N_MASTERS-1:0]    m_err_o,
   output logic                    s_cyc_o,
   output logic                    s_stb_o,
   output logic                    s_we_o,
   output logic [31:0]             s_adr_o,
   output logic [31:0]             s_dat_o,
   output logic [3:0]              s_sel_o,
   input  logic [31:0]             s_dat_i,
   input  logic                    s_ack_i,
   output logic [N_MASTERS-1:0]    grant_o,
   output logic                    timeout_o
);

   localparam int IW = $clog2(N_MASTERS);
   localparam int WW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [IW-1:0] LAST_IDX  = IW'(N_MASTERS - 1);
   localparam logic [WW-1:0] WDOG_LAST = (TIMEOUT_CYCLES > 0) ? WW'(TIMEOUT_CYCLES - 1) : '0;

   typedef enum logic [1:0] {IDLE, GRANT, ABORT} state_t;

   state_t               state_q, state_d;
   logic [N_MASTERS-1:0] grant_q, grant_d;
   logic [IW-1:0]        gidx_q, gidx_d;
   logic [IW-1:0]        ptr_q, ptr_d;
   logic [WW-1:0]        wdog_q, wdog_d;

   logic                 cyc_g, stb_g, stb_act, wdog_hit, found;
   logic [IW-1:0]        pick, scan, gidx_inc;

   always_comb begin
      cyc_g = 1'b0;
      stb_g = 1'b0;
      for (int i = 0; i < N_MASTERS; i++) begin
         if (gidx_q == IW'(i)) begin
            cyc_g = m_cyc_i[i];
            stb_g = m_stb_i[i];
         end
      end
   end

   assign stb_act  = (state_q == GRANT) && cyc_g && stb_g;
   // ACK on the final watchdog cycle suppresses the abort
   assign wdog_hit = (TIMEOUT_CYCLES != 0) && stb_act && !s_ack_i && (wdog_q == WDOG_LAST);
   assign gidx_inc = (gidx_q == LAST_IDX) ? '0 : gidx_q + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         ptr_q   <= '0;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         ptr_q   <= ptr_d;
         wdog_q  <= wdog_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gidx_d  = gidx_q;
      ptr_d   = ptr_q;
      wdog_d  = wdog_q;
      found   = 1'b0;
      pick    = '0;
      scan    = ptr_q;
      for (int k = 0; k < N_MASTERS; k++) begin
         if (!found && m_cyc_i[scan]) begin
            found = 1'b1;
            pick  = scan;
         end
         scan = (scan == LAST_IDX) ? '0 : scan + 1'b1;
      end
      case (state_q)
         IDLE: begin
            if (found) begin
               grant_d       = '0;
               grant_d[pick] = 1'b1;
               gidx_d        = pick;
               state_d       = GRANT;
            end
         end
         GRANT: begin
            if (!cyc_g) begin
               state_d = IDLE;
               grant_d = '0;
               ptr_d   = gidx_inc;
               wdog_d  = '0;
            end else if (wdog_hit) begin
               state_d = ABORT;
               wdog_d  = '0;
            end else if (stb_act && !s_ack_i) begin
               wdog_d = (wdog_q == '1) ? wdog_q : wdog_q + 1'b1;
            end else begin
               wdog_d = '0;
            end
         end
         ABORT: begin
            if (!cyc_g) begin
               state_d = IDLE;
               grant_d = '0;
               ptr_d   = gidx_inc;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      s_cyc_o   = 1'b0;
      s_stb_o   = 1'b0;
      s_we_o    = 1'b0;
      s_adr_o   = '0;
      s_dat_o   = '0;
      s_sel_o   = '0;
      m_ack_o   = '0;
      m_err_o   = '0;
      timeout_o = wdog_hit;
      if (state_q == GRANT) begin
         s_cyc_o = cyc_g;
         s_stb_o = stb_act;
         for (int i = 0; i < N_MASTERS; i++) begin
            if (gidx_q == IW'(i)) begin
               s_we_o     = m_we_i[i];
               s_adr_o    = m_adr_i[32*i +: 32];
               s_dat_o    = m_dat_i[32*i +: 32];
               s_sel_o    = m_sel_i[4*i +: 4];
               m_ack_o[i] = s_ack_i;
               m_err_o[i] = wdog_hit;
            end
         end
      end
   end

   assign m_dat_o = s_dat_i;
   assign grant_o = grant_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: behavioural masters and slave, a scoreboard of expected
// grant/ack/err events, and directed timing checks around each scenario.
module tb_wb_rr_arbiter;

   localparam int N  = 3;
   localparam int TO = 8;
   localparam int EV_G = 0, EV_A = 1, EV_E = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic [N-1:0]      m_cyc_i, m_stb_i, m_we_i;
   logic [32*N-1:0]   m_adr_i, m_dat_i;
   logic [4*N-1:0]    m_sel_i;
   logic [31:0]       m_dat_o;
   logic [N-1:0]      m_ack_o, m_err_o;
   logic              s_cyc_o, s_stb_o, s_we_o;
   logic [31:0]       s_adr_o, s_dat_o;
   logic [3:0]        s_sel_o;
   logic [31:0]       s_dat_i;
   logic              s_ack_i;
   logic [N-1:0]      grant_o;
   logic              timeout_o;

   always #5 clk = ~clk;

   wb_rr_arbiter #(.N_MASTERS(N), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset),
      .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
      .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
      .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
      .grant_o(grant_o), .timeout_o(timeout_o)
   );

   typedef struct {
      int          kind;
      logic [N-1:0] vec;
      logic [31:0] dat;
   } ev_t;

   ev_t sb[$];
   int  total = 0;
   int  bad   = 0;

   // master / slave model state
   int   reqs[N], beats[N], left[N], beat_no[N], err_hold[N], hold_cnt[N];
   bit   active[N], rest[N], aborting[N], is_wr[N], acked[N], erred[N];
   int   slave_wait;
   logic [3:0] dead;
   int   scnt;

   function automatic logic [31:0] adr_of(input int i, input int b);
      return 32'h1000_0000 + 32'(i << 8) + 32'(b << 2);
   endfunction

   function automatic logic [31:0] rdat_of(input logic [31:0] a);
      return {8'hD0, a[23:0]};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic push(input int kind, input int i, input int b);
      ev_t e;
      e.kind = kind;
      e.vec  = '0;
      e.vec[i] = 1'b1;
      e.dat  = (kind == EV_A) ? rdat_of(adr_of(i, b)) : 32'h0;
      sb.push_back(e);
   endtask

   task automatic clear_model();
      for (int i = 0; i < N; i++) begin
         reqs[i] = 0; beats[i] = 1; left[i] = 0; beat_no[i] = 0;
         err_hold[i] = 0; hold_cnt[i] = 0;
         active[i] = 0; rest[i] = 0; aborting[i] = 0; is_wr[i] = 0;
         acked[i] = 0; erred[i] = 0;
      end
      slave_wait = 0;
      dead = '0;
   endtask

   // masters: decide from last negedge samples, drive just after the clock edge
   initial begin
      m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
      m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (active[i]) begin
               if (aborting[i]) begin
                  if (hold_cnt[i] == 0) begin
                     active[i] = 0; aborting[i] = 0; reqs[i] = 0; rest[i] = 1;
                  end else hold_cnt[i]--;
               end else if (erred[i]) begin
                  if (err_hold[i] == 0) begin
                     active[i] = 0; reqs[i] = 0; rest[i] = 1;
                  end else begin
                     aborting[i] = 1; hold_cnt[i] = err_hold[i] - 1;
                  end
               end else if (acked[i]) begin
                  beat_no[i]++;
                  left[i]--;
                  if (left[i] == 0) begin
                     active[i] = 0; reqs[i]--; rest[i] = 1;
                  end
               end
            end else if (rest[i]) begin
               rest[i] = 0;
            end else if (reqs[i] > 0) begin
               active[i] = 1; left[i] = beats[i]; beat_no[i] = 0;
            end
            acked[i] = 0;
            erred[i] = 0;
            m_cyc_i[i] = active[i];
            m_stb_i[i] = active[i];
            m_we_i[i]  = is_wr[i];
            m_adr_i[32*i +: 32] = adr_of(i, beat_no[i]);
            m_dat_i[32*i +: 32] = ~adr_of(i, beat_no[i]);
            m_sel_i[4*i +: 4]   = 4'hF;
         end
      end
   end

   // slave: ACK after slave_wait wait states, never for masters marked dead
   initial begin
      s_ack_i = 1'b0;
      s_dat_i = '0;
      scnt    = 0;
      forever begin
         @(posedge clk);
         #2;
         if (s_cyc_o && s_stb_o && !dead[s_adr_o[9:8]]) begin
            if (scnt == slave_wait) begin
               s_ack_i = 1'b1;
               s_dat_i = rdat_of(s_adr_o);
               scnt    = 0;
            end else begin
               s_ack_i = 1'b0;
               scnt++;
            end
         end else begin
            s_ack_i = 1'b0;
            scnt    = 0;
         end
      end
   end

   task automatic check_evt(input int kind, input logic [N-1:0] vec, input logic [31:0] dat);
      ev_t e;
      total++;
      if (sb.size() == 0) begin
         bad++;
         $display("FAIL sb_unexpected: got kind=%0d vec=%b dat=%h want no event", kind, vec, dat);
      end else begin
         e = sb.pop_front();
         if (e.kind != kind || e.vec !== vec || e.dat !== dat) begin
            bad++;
            $display("FAIL sb_event: got kind=%0d vec=%b dat=%h want kind=%0d vec=%b dat=%h",
                     kind, vec, dat, e.kind, e.vec, e.dat);
         end
      end
   endtask

   // monitor: turns DUT outputs into events and matches them against the scoreboard
   initial begin
      logic [N-1:0] prev_g;
      prev_g = '0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (grant_o != prev_g && grant_o != '0) check_evt(EV_G, grant_o, 32'h0);
            if (|m_ack_o) begin
               check_evt(EV_A, m_ack_o, m_dat_o);
               for (int i = 0; i < N; i++) if (m_ack_o[i]) acked[i] = 1;
            end
            if (|m_err_o) begin
               check_evt(EV_E, m_err_o, 32'h0);
               chk("timeout_with_err", 32'(timeout_o), 32'h1);
               for (int i = 0; i < N; i++) if (m_err_o[i]) erred[i] = 1;
            end else if (timeout_o) begin
               chk("timeout_without_err", 32'(timeout_o), 32'h0);
            end
         end
         prev_g = grant_o;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      clear_model();
      repeat (2) @(negedge clk);
      chk("rst_grant", 32'(grant_o), 32'h0);
      chk("rst_outs", {28'h0, s_cyc_o, s_stb_o, s_we_o, timeout_o}, 32'h0);
      chk("rst_ackerr", {26'h0, m_ack_o, m_err_o}, 32'h0);
      chk("rst_adr", s_adr_o, 32'h0);
      reset = 1'b0;
   endtask

   task automatic wait_drain(input string nm);
      int n;
      for (n = 0; n < 300 && sb.size() != 0; n++) @(negedge clk);
      chk({nm, "_drained"}, 32'(sb.size()), 32'h0);
      sb.delete();
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int n;
      bit seen_to;
      logic [N-1:0] exp_g2 [10];
      reset = 1'b1;
      clear_model();

      // 1: single master 1 read, two wait states
      do_reset();
      slave_wait = 2;
      push(EV_G, 1, 0);
      push(EV_A, 1, 0);
      reqs[1] = 1;
      @(negedge clk); chk("t1_c0_grant", 32'(grant_o), 32'h0);
      @(negedge clk); chk("t1_c1_grant", 32'(grant_o), 32'h2);
      @(negedge clk); chk("t1_c2_ack", 32'(m_ack_o), 32'h0);
      @(negedge clk); chk("t1_c3_ack", 32'(m_ack_o), 32'h2);
      chk("t1_c3_dat", m_dat_o, rdat_of(adr_of(1, 0)));
      @(negedge clk); chk("t1_c4_scyc", 32'(s_cyc_o), 32'h0);
      chk("t1_c4_grant", 32'(grant_o), 32'h2);
      @(negedge clk); chk("t1_c5_grant", 32'(grant_o), 32'h0);
      wait_drain("t1");

      // 2: all masters request continuously, one idle cycle between owners
      do_reset();
      exp_g2 = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b000, 3'b100, 3'b100, 3'b000};
      for (int r = 0; r < 3; r++)
         for (int i = 0; i < N; i++) begin
            push(EV_G, i, 0);
            push(EV_A, i, 0);
         end
      for (int i = 0; i < N; i++) reqs[i] = 3;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk($sformatf("t2_grant_c%0d", c), 32'(grant_o), 32'(exp_g2[c]));
      end
      wait_drain("t2");

      // 3: master 0 holds CYC over 4 beats while master 2 waits
      do_reset();
      slave_wait = 1;
      push(EV_G, 0, 0);
      for (int b = 0; b < 4; b++) push(EV_A, 0, b);
      push(EV_G, 2, 0);
      push(EV_A, 2, 0);
      beats[0] = 4;
      reqs[0]  = 1;
      reqs[2]  = 1;
      wait_drain("t3");

      // 4: slave never ACKs master 1 -> watchdog abort, then master 2 served
      do_reset();
      dead      = 4'b0010;
      err_hold[1] = 3;
      push(EV_G, 1, 0);
      push(EV_E, 1, 0);
      push(EV_G, 2, 0);
      push(EV_A, 2, 0);
      reqs[1] = 1;
      reqs[2] = 1;
      for (n = 0; n < 40; n++) begin
         @(negedge clk);
         if (m_err_o[1]) break;
      end
      chk("t4_err_latency", 32'(n), 32'd8);
      chk("t4_timeout_pulse", 32'(timeout_o), 32'h1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("t4_abort_bus", {30'h0, s_cyc_o, s_stb_o}, 32'h0);
         chk("t4_abort_grant", 32'(grant_o), 32'h2);
      end
      @(negedge clk);
      @(negedge clk); chk("t4_idle_grant", 32'(grant_o), 32'h0);
      @(negedge clk); chk("t4_next_grant", 32'(grant_o), 32'h4);
      wait_drain("t4");

      // 5: ACK lands exactly on the timeout cycle
      do_reset();
      slave_wait = 7;
      push(EV_G, 0, 0);
      push(EV_A, 0, 0);
      reqs[0] = 1;
      seen_to = 0;
      for (n = 0; n < 40; n++) begin
         @(negedge clk);
         if (timeout_o || (|m_err_o)) seen_to = 1;
         if (m_ack_o[0]) break;
      end
      chk("t5_ack_latency", 32'(n), 32'd8);
      chk("t5_no_timeout", 32'(seen_to), 32'h0);
      wait_drain("t5");

      // 6: reset during a granted write restarts priority at master 0
      do_reset();
      push(EV_G, 0, 0);
      push(EV_A, 0, 0);
      reqs[0] = 1;
      wait_drain("t6a");
      dead     = 4'b0010;
      is_wr[1] = 1;
      push(EV_G, 1, 0);
      reqs[1] = 1;
      for (n = 0; n < 20; n++) begin
         @(negedge clk);
         if (grant_o == 3'b010) break;
      end
      chk("t6_granted", 32'(grant_o), 32'h2);
      chk("t6_write", {30'h0, s_cyc_o, s_we_o}, 32'h3);
      reset = 1'b1;
      clear_model();
      @(negedge clk);
      chk("t6_rst_grant", 32'(grant_o), 32'h0);
      chk("t6_rst_bus", {29'h0, s_cyc_o, s_stb_o, s_we_o}, 32'h0);
      chk("t6_rst_adr", s_adr_o, 32'h0);
      chk("t6_rst_ackerr", {25'h0, timeout_o, m_ack_o, m_err_o}, 32'h0);
      reset = 1'b0;
      chk("t6_sb_after_rst", 32'(sb.size()), 32'h0);
      push(EV_G, 0, 0);
      push(EV_A, 0, 0);
      push(EV_G, 1, 0);
      push(EV_A, 1, 0);
      reqs[0] = 1;
      reqs[1] = 1;
      wait_drain("t6b");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
